// File: rtl/pipeline_pkg.sv
// pipeline_pkg: types and constants shared by the RV32I pipeline stages.
//   NOP_INSTR     - canonical bubble instruction (addi x0, x0, 0)
//   pcsrc_e       - execute-stage next-PC source select
//   fetch_state_e - fetch sequencer states
//   if_id_t       - IF/ID pipeline register contents
package pipeline_pkg;

  localparam int unsigned PIPE_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // 2'b11 has no name of its own; it behaves like PCSRC_BR.
  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_JALR = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10,
    DROP = 2'b11
  } fetch_state_e;

  // Field widths follow PIPE_XLEN; fetch_stage is built with XLEN == PIPE_XLEN.
  typedef struct packed {
    logic [31:0]          instr;
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] pc_plus4;
    logic                 valid;
  } if_id_t;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC candidates for the fetch stage.
//   pcf        in  current fetch PC
//   pcsrc      in  execute-stage PC source (00 seq, 01/11 branch, 10 JALR)
//   pc_target  in  branch/JAL target
//   alu_result in  JALR target (bit0 is cleared here)
//   redir      out execute stage is redirecting fetch this cycle
//   redir_pc   out word-aligned redirect target
//   seq_pc     out word-aligned pcf + 4 (wraps modulo 2^XLEN)
module pc_next_mux
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pcf,
  input  logic [1:0]      pcsrc,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  output logic            redir,
  output logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] seq_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    redir = (pcsrc != PCSRC_SEQ);
    if (pcsrc == PCSRC_JALR) begin
      raw_target = alu_result & ~XLEN'(1);
    end else begin
      raw_target = pc_target;
    end
    // Every value loaded into PCF is word aligned.
    redir_pc = raw_target & ALIGN_MASK;
    seq_pc   = (pcf + XLEN'(4)) & ALIGN_MASK;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the RV32I pipeline. Owns PCF, issues one
// instruction-memory request at a time and drives the IF/ID register.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   PCen_i, Fen_i, Frst_i  hazard unit: PC enable, IF/ID enable, IF/ID flush
//   PCSrcE_i, PCTargetE_i, ALUResultE_i  execute-stage redirect
//   imem_req_o, imem_addr_o              request pulse and address (= PCF)
//   imem_rvalid_i, imem_rdata_i          response, >= 1 cycle after request
//   InstrD_o, PCD_o, PCPlus4D_o, ValidD_o  IF/ID register
//   fetch_state_o          debug view of the sequencer state
//
// Memory handshake: imem_req_o is a one-cycle pulse (no ready); each pulse
// is answered by exactly one imem_rvalid_i pulse carrying imem_rdata_i, and
// no new pulse is issued until that answer has been consumed.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned     XLEN     = PIPE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            PCen_i,
  input  logic            Fen_i,
  input  logic            Frst_i,
  input  logic [1:0]      PCSrcE_i,
  input  logic [XLEN-1:0] PCTargetE_i,
  input  logic [XLEN-1:0] ALUResultE_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     InstrD_o,
  output logic [XLEN-1:0] PCD_o,
  output logic [XLEN-1:0] PCPlus4D_o,
  output logic            ValidD_o,
  output fetch_state_e    fetch_state_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  if_id_t          if_id_q, if_id_d;

  logic            redir;
  logic            adv;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] seq_pc;
  logic            deliver;
  logic [31:0]     dlv_instr;
  logic [XLEN-1:0] dlv_pc;

  pc_next_mux #(.XLEN(XLEN)) u_pc_next_mux (
    .pcf        (pcf_q),
    .pcsrc      (PCSrcE_i),
    .pc_target  (PCTargetE_i),
    .alu_result (ALUResultE_i),
    .redir      (redir),
    .redir_pc   (redir_pc),
    .seq_pc     (seq_pc)
  );

  // PCen without Fen is a stall: PCF only moves together with a delivery.
  assign adv = PCen_i & Fen_i;

  assign imem_req_o    = (state_q == REQ) & rst_ni;
  assign imem_addr_o   = pcf_q;
  assign fetch_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= REQ;
      pcf_q        <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      if_id_q      <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      if_id_q      <= if_id_d;
    end
  end

  // Sequencer. A redirect always wins over a response; a response that
  // belongs to a pre-redirect PC is swallowed in DROP.
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    deliver      = 1'b0;
    dlv_instr    = imem_rdata_i;
    dlv_pc       = pcf_q;
    case (state_q)
      REQ: begin
        // Any response seen here predates a reset and is ignored.
        if (redir) begin
          pcf_d   = redir_pc;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (redir) begin
            pcf_d   = redir_pc;
            state_d = REQ;
          end else if (adv) begin
            deliver = 1'b1;
            pcf_d   = seq_pc;
            state_d = REQ;
          end else begin
            hold_instr_d = imem_rdata_i;
            hold_pc_d    = pcf_q;
            state_d      = HOLD;
          end
        end else if (redir) begin
          pcf_d   = redir_pc;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (redir) begin
          pcf_d   = redir_pc;
          state_d = REQ;
        end else if (adv) begin
          deliver   = 1'b1;
          dlv_instr = hold_instr_q;
          dlv_pc    = hold_pc_q;
          pcf_d     = seq_pc;
          state_d   = REQ;
        end
      end
      DROP: begin
        // A fresh redirect retargets PCF. The stale response is consumed
        // whenever it shows up, even on a redirect cycle; waiting on past it
        // would wait for an answer that never comes.
        if (redir) begin
          pcf_d = redir_pc;
        end
        if (imem_rvalid_i) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // IF/ID update: flush/redirect bubble > stall hold > load > bubble.
  // Bubbles keep the PC fields so decode still sees the last PC.
  always_comb begin
    if_id_d = if_id_q;
    if (redir || Frst_i) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (Fen_i) begin
      if (deliver) begin
        if_id_d.instr    = dlv_instr;
        if_id_d.pc       = dlv_pc;
        if_id_d.pc_plus4 = dlv_pc + XLEN'(4);
        if_id_d.valid    = 1'b1;
      end else begin
        if_id_d.instr = NOP_INSTR;
        if_id_d.valid = 1'b0;
      end
    end
  end

  assign InstrD_o   = if_id_q.instr;
  assign PCD_o      = if_id_q.pc;
  assign PCPlus4D_o = if_id_q.pc_plus4;
  assign ValidD_o   = if_id_q.valid;

endmodule
